// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDC = 4'b0100;
    localparam logic [3:0] OP_SUBC = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_SAR  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles, low WIDTH bits kept.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                acc_reg    <= '0;
                mcand_reg  <= a;
                mplier_reg <= b;
                cnt_reg    <= '0;
                busy_reg   <= 1'b1;
            end else if (busy_reg) begin
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CW'(1);
                // done pulses the cycle after the last partial product is added
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign product = acc_reg;
    assign done    = done_reg;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with a {N,Z,C,V} flag register.
// Define ALU_SEQ_MUL_EN to enable the iterative multiply on opcode 1100.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_ina,
    input  logic [WIDTH-1:0] src_inb,
    input  logic [3:0]       alu_control,
    input  logic             swap,
    input  logic             flag_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       alu_flags
);

    alu_state_t       state_reg;
    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flags_reg;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH:0]   wide_next;
    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic             ovf_next;
    logic             supported_next;
    logic             is_mul_next;
    logic             accept;

    assign src_a  = swap ? src_inb : src_ina;
    assign src_b  = swap ? src_ina : src_inb;
    assign accept = in_valid && (state_reg == ST_IDLE);

    // Single-cycle datapath evaluated on the accept edge; carry-in comes from the flag register.
    always_comb begin
        wide_next      = '0;
        result_next    = '0;
        carry_next     = 1'b0;
        ovf_next       = 1'b0;
        supported_next = 1'b1;
        is_mul_next    = 1'b0;
        case (alu_control)
            OP_ADD, OP_ADDC: begin
                wide_next   = {1'b0, src_a} + {1'b0, src_b}
                            + {{WIDTH{1'b0}}, (alu_control == OP_ADDC) & flags_reg[FLAG_C]};
                result_next = wide_next[WIDTH-1:0];
                carry_next  = wide_next[WIDTH];
                ovf_next    = (src_a[WIDTH-1] == src_b[WIDTH-1])
                           && (result_next[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB, OP_SUBC: begin
                wide_next   = {1'b0, src_a} - {1'b0, src_b}
                            - {{WIDTH{1'b0}}, (alu_control == OP_SUBC) & flags_reg[FLAG_C]};
                result_next = wide_next[WIDTH-1:0];
                carry_next  = wide_next[WIDTH];
                ovf_next    = (src_a[WIDTH-1] != src_b[WIDTH-1])
                           && (result_next[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND: result_next = src_a & src_b;
            OP_OR:  result_next = src_a | src_b;
            OP_XOR: result_next = src_a ^ src_b;
            OP_SHL: result_next = src_a << src_b[SHW-1:0];
            OP_SHR: result_next = src_a >> src_b[SHW-1:0];
            OP_SAR: result_next = $signed(src_a) >>> src_b[SHW-1:0];
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: is_mul_next = 1'b1;
`endif
            default: supported_next = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic             flag_we_reg;
    logic [WIDTH-1:0] mul_product;
    logic             mul_done;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul_next),
        .a       (src_a),
        .b       (src_b),
        .product (mul_product),
        .done    (mul_done)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            result_reg <= '0;
            flags_reg  <= 4'b0000;
`ifdef ALU_SEQ_MUL_EN
            flag_we_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul_next) begin
                            state_reg <= ST_BUSY;
`ifdef ALU_SEQ_MUL_EN
                            flag_we_reg <= flag_we;
`endif
                        end else begin
                            state_reg  <= ST_DONE;
                            result_reg <= result_next;
                            if (flag_we && supported_next) begin
                                flags_reg <= {result_next[WIDTH-1], ~|result_next,
                                              carry_next, ovf_next};
                            end
                        end
                    end
                end
                ST_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
                    if (mul_done) begin
                        state_reg  <= ST_DONE;
                        result_reg <= mul_product;
                        if (flag_we_reg) begin
                            flags_reg <= {mul_product[WIDTH-1], ~|mul_product, 2'b00};
                        end
                    end
`else
                    state_reg <= ST_IDLE;
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_reg == ST_IDLE);
    assign out_valid  = (state_reg == ST_DONE);
    assign alu_result = result_reg;
    assign alu_flags  = flags_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32; multiply tests run when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src_ina;
    logic [31:0] src_inb;
    logic [3:0]  alu_control;
    logic        swap;
    logic        flag_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;

    int n_pass  = 0;
    int n_total = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_ina     (src_ina),
        .src_inb     (src_inb),
        .alu_control (alu_control),
        .swap        (swap),
        .flag_we     (flag_we),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request for one cycle; returns 1 time unit after the accept edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sw, input logic fwe);
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = op;
        src_ina     = a;
        src_inb     = b;
        swap        = sw;
        flag_we     = fwe;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("op=%b a=%h b=%h swap=%0d fwe=%0d -> valid=%0d result=%h flags=%b",
                 op, a, b, sw, fwe, out_valid, alu_result, alu_flags);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (alu_result !== 32'h0) $display("FAIL rst_result: got %h want 0", alu_result); else n_pass++;
        n_total++; if (alu_flags !== 4'b0000) $display("FAIL rst_flags: got %b want 0000", alu_flags); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        send(4'b0000, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
        n_total++; if (out_valid !== 1'b1) $display("FAIL add_latency: got %b want 1", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL add_in_ready: got %b want 0", in_ready); else n_pass++;
        n_total++; if (alu_result !== 32'h0) $display("FAIL add_result: got %h want 00000000", alu_result); else n_pass++;
        n_total++; if (alu_flags !== 4'b0110) $display("FAIL add_flags: got %b want 0110", alu_flags); else n_pass++;
        consume();
        send(4'b0100, 32'h0, 32'h0, 1'b0, 1'b0);
        n_total++; if (alu_result !== 32'h1) $display("FAIL addc_result: got %h want 00000001", alu_result); else n_pass++;
        n_total++; if (alu_flags !== 4'b0110) $display("FAIL addc_flags_kept: got %b want 0110", alu_flags); else n_pass++;
        consume();
    endtask

    task automatic test_sub();
        send(4'b0001, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
        n_total++; if (alu_result !== 32'h7FFF_FFFF) $display("FAIL sub_result: got %h want 7fffffff", alu_result); else n_pass++;
        n_total++; if (alu_flags !== 4'b0001) $display("FAIL sub_flags: got %b want 0001", alu_flags); else n_pass++;
        consume();
        send(4'b0001, 32'd3, 32'd5, 1'b1, 1'b0);
        n_total++; if (alu_result !== 32'h2) $display("FAIL sub_swap: got %h want 00000002", alu_result); else n_pass++;
        consume();
        send(4'b0001, 32'h0, 32'h1, 1'b0, 1'b1);
        n_total++; if (alu_flags !== 4'b1010) $display("FAIL sub_borrow_flags: got %b want 1010", alu_flags); else n_pass++;
        consume();
        send(4'b0101, 32'd10, 32'd3, 1'b0, 1'b0);
        n_total++; if (alu_result !== 32'd6) $display("FAIL subc_result: got %h want 00000006", alu_result); else n_pass++;
        consume();
    endtask

    task automatic test_logic_shift();
        send(4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 1'b0);
        n_total++; if (alu_result !== 32'h00F0_00F0) $display("FAIL and_result: got %h want 00f000f0", alu_result); else n_pass++;
        consume();
        send(4'b0011, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 1'b0);
        n_total++; if (alu_result !== 32'hF0F0_0F0F) $display("FAIL or_result: got %h want f0f00f0f", alu_result); else n_pass++;
        consume();
        send(4'b0111, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0);
        n_total++; if (alu_result !== 32'hF0F0_0F0F) $display("FAIL xor_result: got %h want f0f00f0f", alu_result); else n_pass++;
        consume();
        send(4'b1000, 32'h1, 32'd31, 1'b0, 1'b0);
        n_total++; if (alu_result !== 32'h8000_0000) $display("FAIL shl_result: got %h want 80000000", alu_result); else n_pass++;
        consume();
        send(4'b1000, 32'h1, 32'd33, 1'b0, 1'b0);
        n_total++; if (alu_result !== 32'h2) $display("FAIL shl_amount_mask: got %h want 00000002", alu_result); else n_pass++;
        consume();
        send(4'b1001, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
        n_total++; if (alu_result !== 32'h0800_0000) $display("FAIL shr_result: got %h want 08000000", alu_result); else n_pass++;
        consume();
        send(4'b1010, 32'h8000_0000, 32'd4, 1'b0, 1'b1);
        n_total++; if (alu_result !== 32'hF800_0000) $display("FAIL sar_result: got %h want f8000000", alu_result); else n_pass++;
        n_total++; if (alu_flags !== 4'b1000) $display("FAIL sar_flags: got %b want 1000", alu_flags); else n_pass++;
        consume();
    endtask

    task automatic test_unsupported();
        send(4'b0110, 32'h1234_5678, 32'h1, 1'b0, 1'b1);
        n_total++; if (out_valid !== 1'b1) $display("FAIL unsup_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (alu_result !== 32'h0) $display("FAIL unsup_result: got %h want 00000000", alu_result); else n_pass++;
        n_total++; if (alu_flags !== 4'b1000) $display("FAIL unsup_flags: got %b want 1000", alu_flags); else n_pass++;
        consume();
`ifndef ALU_SEQ_MUL_EN
        send(4'b1100, 32'h0001_0000, 32'h0001_0001, 1'b0, 1'b1);
        n_total++; if (out_valid !== 1'b1) $display("FAIL mul_off_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (alu_result !== 32'h0) $display("FAIL mul_off_result: got %h want 00000000", alu_result); else n_pass++;
        n_total++; if (alu_flags !== 4'b1000) $display("FAIL mul_off_flags: got %b want 1000", alu_flags); else n_pass++;
        consume();
`endif
    endtask

    task automatic test_hold();
        send(4'b0000, 32'd5, 32'd6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_total++; if (out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
            n_total++; if (alu_result !== 32'd11) $display("FAIL hold_result[%0d]: got %h want 0000000b", i, alu_result); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); else n_pass++;
            @(posedge clk);
            #1;
        end
        consume();
        n_total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL release_out_valid: got %b want 0", out_valid); else n_pass++;
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul();
        int bad;
        send(4'b0001, 32'h0, 32'h1, 1'b0, 1'b1);
        consume();
        send(4'b1100, 32'h0001_0000, 32'h0001_0001, 1'b0, 1'b1);
        bad = 0;
        for (int k = 0; k <= 32; k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            if (k < 32) begin
                @(posedge clk);
                #1;
            end
        end
        n_total++; if (bad != 0) $display("FAIL mul_busy_window: got %0d bad cycles want 0", bad); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b1) $display("FAIL mul_latency33: got %b want 1", out_valid); else n_pass++;
        n_total++; if (alu_result !== 32'h0001_0000) $display("FAIL mul_result: got %h want 00010000", alu_result); else n_pass++;
        n_total++; if (alu_flags !== 4'b0000) $display("FAIL mul_flags: got %b want 0000", alu_flags); else n_pass++;
        consume();
    endtask
`endif

    // Reset during an in-flight operation (BUSY with multiply, otherwise DONE).
    task automatic test_reset_mid();
        send(4'b0001, 32'h0, 32'h1, 1'b0, 1'b1);
        consume();
`ifdef ALU_SEQ_MUL_EN
        send(4'b1100, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
`else
        send(4'b0000, 32'h7, 32'h8, 1'b0, 1'b1);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (alu_flags !== 4'b0000) $display("FAIL mid_rst_flags: got %b want 0000", alu_flags); else n_pass++;
        n_total++; if (alu_result !== 32'h0) $display("FAIL mid_rst_result: got %h want 00000000", alu_result); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        send(4'b0000, 32'd2, 32'd3, 1'b0, 1'b0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL post_rst_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (alu_result !== 32'd5) $display("FAIL post_rst_result: got %h want 00000005", alu_result); else n_pass++;
        consume();
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        src_ina     = '0;
        src_inb     = '0;
        alu_control = '0;
        swap        = 1'b0;
        flag_we     = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_logic_shift();
        test_unsupported();
        test_hold();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
